// File: rtl/id_stage_pkg.sv
// Shared constants for the decode stage: ALU funct codes, MIPS opcodes and R-type funct fields.
package id_stage_pkg;

  localparam logic [4:0] FUNCT_ADD  = 5'd0;
  localparam logic [4:0] FUNCT_SUB  = 5'd1;
  localparam logic [4:0] FUNCT_AND  = 5'd2;
  localparam logic [4:0] FUNCT_OR   = 5'd3;
  localparam logic [4:0] FUNCT_XOR  = 5'd4;
  localparam logic [4:0] FUNCT_SLT  = 5'd5;
  localparam logic [4:0] FUNCT_SLTU = 5'd6;
  localparam logic [4:0] FUNCT_SLL  = 5'd7;
  localparam logic [4:0] FUNCT_SRL  = 5'd8;
  localparam logic [4:0] FUNCT_SRA  = 5'd9;
  localparam logic [4:0] FUNCT_EQ   = 5'd10;
  localparam logic [4:0] FUNCT_NEQ  = 5'd11;
  localparam logic [4:0] FUNCT_GE   = 5'd12;
  localparam logic [4:0] FUNCT_GEU  = 5'd13;
  localparam logic [4:0] FUNCT_ADDU = 5'd14;
  localparam logic [4:0] FUNCT_BEQ  = 5'd15;
  localparam logic [4:0] FUNCT_BNE  = 5'd16;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] RF_SLL  = 6'h00;
  localparam logic [5:0] RF_SRL  = 6'h02;
  localparam logic [5:0] RF_SRA  = 6'h03;
  localparam logic [5:0] RF_ADD  = 6'h20;
  localparam logic [5:0] RF_ADDU = 6'h21;
  localparam logic [5:0] RF_SUB  = 6'h22;
  localparam logic [5:0] RF_SUBU = 6'h23;
  localparam logic [5:0] RF_AND  = 6'h24;
  localparam logic [5:0] RF_OR   = 6'h25;
  localparam logic [5:0] RF_XOR  = 6'h26;
  localparam logic [5:0] RF_SLT  = 6'h2A;
  localparam logic [5:0] RF_SLTU = 6'h2B;

endpackage

// File: rtl/id_stage_if.sv
// ID/EX issue bus: decode stage drives (master), EX stage consumes (slave).
interface id_stage_if #(
    parameter int DWIDTH    = 32,
    parameter int PC_WIDTH  = 32,
    parameter int IMM_WIDTH = 16
);
    logic                 d_o_valid;
    logic [4:0]           d_o_funct;
    logic                 d_o_alu_src;
    logic [IMM_WIDTH-1:0] d_o_imm;
    logic [DWIDTH-1:0]    d_o_data_rs;
    logic [DWIDTH-1:0]    d_o_data_rt;
    logic [PC_WIDTH-1:0]  d_o_pc;
    logic [4:0]           d_o_rd_addr;
    logic                 d_o_reg_write;
    logic                 d_o_mem_read;
    logic                 d_o_mem_write;
    logic                 d_o_illegal;

    modport master (
        output d_o_valid, d_o_funct, d_o_alu_src, d_o_imm, d_o_data_rs, d_o_data_rt,
               d_o_pc, d_o_rd_addr, d_o_reg_write, d_o_mem_read, d_o_mem_write, d_o_illegal
    );
    modport slave (
        input  d_o_valid, d_o_funct, d_o_alu_src, d_o_imm, d_o_data_rs, d_o_data_rt,
               d_o_pc, d_o_rd_addr, d_o_reg_write, d_o_mem_read, d_o_mem_write, d_o_illegal
    );
endinterface

// File: rtl/id_decode.sv
// Pure combinational MIPS decoder: instruction word to ALU/memory/writeback controls.
module id_decode
    import id_stage_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  funct,
    output logic        alu_src,
    output logic [15:0] imm,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        illegal,
    output logic        uses_rt,
    output logic        swap_for_shift
);
    logic [5:0] opcode, rfunct;
    logic       has_dst;

    assign opcode = instr[31:26];
    assign rfunct = instr[5:0];

    always_comb begin
        funct          = FUNCT_ADD;
        alu_src        = 1'b0;
        imm            = instr[15:0];
        rd             = instr[20:16];
        has_dst        = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        illegal        = 1'b0;
        uses_rt        = 1'b0;
        swap_for_shift = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                rd      = instr[15:11];
                has_dst = 1'b1;
                uses_rt = 1'b1;
                case (rfunct)
                    RF_ADD:          funct = FUNCT_ADD;
                    RF_ADDU:         funct = FUNCT_ADDU;
                    RF_SUB, RF_SUBU: funct = FUNCT_SUB;
                    RF_AND:          funct = FUNCT_AND;
                    RF_OR:           funct = FUNCT_OR;
                    RF_XOR:          funct = FUNCT_XOR;
                    RF_SLT:          funct = FUNCT_SLT;
                    RF_SLTU:         funct = FUNCT_SLTU;
                    RF_SLL, RF_SRL, RF_SRA: begin
                        // Shift value travels on the rs lane, shamt rides the immediate
                        funct          = (rfunct == RF_SLL) ? FUNCT_SLL :
                                         (rfunct == RF_SRL) ? FUNCT_SRL : FUNCT_SRA;
                        alu_src        = 1'b1;
                        imm            = {11'b0, instr[10:6]};
                        swap_for_shift = 1'b1;
                    end
                    default:         illegal = 1'b1;
                endcase
            end
            OP_ADDI:  begin funct = FUNCT_ADD;  alu_src = 1'b1; has_dst = 1'b1; end
            OP_ADDIU: begin funct = FUNCT_ADDU; alu_src = 1'b1; has_dst = 1'b1; end
            OP_SLTI:  begin funct = FUNCT_SLT;  alu_src = 1'b1; has_dst = 1'b1; end
            OP_SLTIU: begin funct = FUNCT_SLTU; alu_src = 1'b1; has_dst = 1'b1; end
            OP_LW:    begin alu_src = 1'b1; has_dst = 1'b1; mem_read = 1'b1; end
            OP_SW:    begin alu_src = 1'b1; mem_write = 1'b1; uses_rt = 1'b1; end
            OP_BEQ:   begin funct = FUNCT_BEQ; uses_rt = 1'b1; end
            OP_BNE:   begin funct = FUNCT_BNE; uses_rt = 1'b1; end
            default:  illegal = 1'b1;
        endcase
        reg_write = has_dst && (rd != 5'd0) && !illegal;
    end
endmodule

// File: rtl/id_stage.sv
// Decode stage: load-use hazard detection and the ID/EX pipeline register.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int PC_WIDTH  = 32,
    parameter int IMM_WIDTH = 16
) (
    input  logic                d_clk,
    input  logic                d_rst,
    input  logic                d_i_valid,
    input  logic [31:0]         d_i_instr,
    input  logic [PC_WIDTH-1:0] d_i_pc,
    input  logic [DWIDTH-1:0]   d_i_data_rs,
    input  logic [DWIDTH-1:0]   d_i_data_rt,
    input  logic                d_i_flush,
    input  logic                d_i_stall_ext,
    output logic [4:0]          d_o_rs_addr,
    output logic [4:0]          d_o_rt_addr,
    output logic                d_o_stall,
    id_stage_if.master          ex
);
    logic [4:0]  dec_funct, dec_rd;
    logic [15:0] dec_imm;
    logic        dec_alu_src, dec_reg_write, dec_mem_read, dec_mem_write;
    logic        dec_illegal, dec_uses_rt, dec_swap;
    logic        hazard;

    id_decode u_dec (
        .instr          (d_i_instr),
        .funct          (dec_funct),
        .alu_src        (dec_alu_src),
        .imm            (dec_imm),
        .rd             (dec_rd),
        .reg_write      (dec_reg_write),
        .mem_read       (dec_mem_read),
        .mem_write      (dec_mem_write),
        .illegal        (dec_illegal),
        .uses_rt        (dec_uses_rt),
        .swap_for_shift (dec_swap)
    );

    assign d_o_rs_addr = d_i_instr[25:21];
    assign d_o_rt_addr = d_i_instr[20:16];

    assign hazard = d_i_valid && ex.d_o_valid && ex.d_o_mem_read && (ex.d_o_rd_addr != 5'd0) &&
                    ((ex.d_o_rd_addr == d_o_rs_addr) ||
                     (dec_uses_rt && (ex.d_o_rd_addr == d_o_rt_addr)));
    assign d_o_stall = hazard || d_i_stall_ext;

    // Bubbles only clear the control bits; data fields keep stale values
    always_ff @(posedge d_clk) begin
        if (d_rst) begin
            ex.d_o_valid     <= 1'b0;
            ex.d_o_funct     <= '0;
            ex.d_o_alu_src   <= 1'b0;
            ex.d_o_imm       <= '0;
            ex.d_o_data_rs   <= '0;
            ex.d_o_data_rt   <= '0;
            ex.d_o_pc        <= '0;
            ex.d_o_rd_addr   <= '0;
            ex.d_o_reg_write <= 1'b0;
            ex.d_o_mem_read  <= 1'b0;
            ex.d_o_mem_write <= 1'b0;
            ex.d_o_illegal   <= 1'b0;
        end else if (d_i_stall_ext && !d_i_flush) begin
            ex.d_o_illegal   <= 1'b0;
        end else if (d_i_flush || hazard || !d_i_valid || dec_illegal) begin
            ex.d_o_valid     <= 1'b0;
            ex.d_o_reg_write <= 1'b0;
            ex.d_o_mem_read  <= 1'b0;
            ex.d_o_mem_write <= 1'b0;
            ex.d_o_illegal   <= !d_i_flush && !hazard && d_i_valid && dec_illegal;
        end else begin
            ex.d_o_valid     <= 1'b1;
            ex.d_o_funct     <= dec_funct;
            ex.d_o_alu_src   <= dec_alu_src;
            ex.d_o_imm       <= IMM_WIDTH'(dec_imm);
            ex.d_o_data_rs   <= dec_swap ? d_i_data_rt : d_i_data_rs;
            ex.d_o_data_rt   <= d_i_data_rt;
            ex.d_o_pc        <= d_i_pc + PC_WIDTH'(4);
            ex.d_o_rd_addr   <= dec_rd;
            ex.d_o_reg_write <= dec_reg_write;
            ex.d_o_mem_read  <= dec_mem_read;
            ex.d_o_mem_write <= dec_mem_write;
            ex.d_o_illegal   <= 1'b0;
        end
    end
endmodule
